// File: rtl/mux_pkg.sv
// Shared types and elaboration helpers for the pipelined mux tree.
// Lane-count arithmetic lives here so the top can size every tree level at elaboration.
package mux_pkg;

    localparam int unsigned MUX_MIN_IN = 2;

    typedef struct packed {
        logic valid;
        logic ready;
    } hs_t;

    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Each level halves the lane count, rounding up for an odd trailing lane.
    function automatic int unsigned lanes_at_level(input int unsigned n, input int unsigned k);
        int unsigned l;
        l = n;
        for (int unsigned i = 0; i < k; i++) l = (l + 1) / 2;
        return l;
    endfunction

    function automatic int unsigned level_offset(input int unsigned n, input int unsigned k,
                                                 input int unsigned w);
        int unsigned sum;
        sum = 0;
        for (int unsigned i = 0; i < k; i++) sum += lanes_at_level(n, i) * w;
        return sum;
    endfunction

endpackage

// File: rtl/mux_tree_stage.sv
// One registered level of the mux tree: pairwise 2:1 reduction on select bit 0,
// carrying valid and the remaining select bits alongside the data.
module mux_tree_stage #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned N_LANES = 8,
    parameter int unsigned SEL_W   = 3
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   en,
    input  logic                                   in_valid,
    input  logic [N_LANES*DATA_W-1:0]              in_data,
    input  logic [SEL_W-1:0]                       in_sel,
    output logic                                   out_valid,
    output logic [((N_LANES+1)/2)*DATA_W-1:0]      out_data,
    output logic [SEL_W-1:0]                       out_sel
);

    localparam int unsigned N_OUT = (N_LANES + 1) / 2;

    logic [N_OUT*DATA_W-1:0] data_d;
    logic [N_OUT*DATA_W-1:0] data_q;
    logic [SEL_W-1:0]        sel_d;
    logic [SEL_W-1:0]        sel_q;
    logic                    valid_q;

    for (genvar j = 0; j < N_OUT; j++) begin : gLane
        if (2 * j + 1 < N_LANES) begin : gPair
            assign data_d[j*DATA_W +: DATA_W] = in_sel[0] ? in_data[(2*j+1)*DATA_W +: DATA_W]
                                                          : in_data[(2*j)*DATA_W +: DATA_W];
        end else begin : gPass
            assign data_d[j*DATA_W +: DATA_W] = in_data[(2*j)*DATA_W +: DATA_W];
        end
    end

    // The consumed select bit is shifted out so the next level always looks at bit 0.
    assign sel_d = in_sel >> 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sel_q   <= '0;
        end else if (en) begin
            valid_q <= in_valid;
            data_q  <= data_d;
            sel_q   <= sel_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_sel   = sel_q;

endmodule

// File: rtl/mux_tree_pipe.sv
// N_IN:1 pipelined mux tree with valid/ready flow control and one register per level.
// Optional feature macro MUX_ERR_EN: carries an out-of-range-select flag to out_err.
module mux_tree_pipe
    import mux_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned N_IN   = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N_IN*DATA_W-1:0]        in_data,
    input  logic [clog2_min1(N_IN)-1:0]   in_sel,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W-1:0]             out_data,
    output logic                          out_err
);

    localparam int unsigned SEL_W  = clog2_min1((N_IN < MUX_MIN_IN) ? MUX_MIN_IN : N_IN);
    localparam int unsigned LEVELS = SEL_W;
    localparam int unsigned TOT_W  = level_offset(N_IN, LEVELS + 1, DATA_W);

    logic [TOT_W-1:0]  lvlData;
    logic [LEVELS:0]   lvlValid;
    logic [SEL_W-1:0]  lvlSel [LEVELS+1];
    logic [SEL_W-1:0]  unusedSel;
    logic              adv;
    logic              rangeErr;
    hs_t               outHs;

    // The whole pipe advances together; a stalled output freezes every level.
    assign outHs     = '{valid: lvlValid[LEVELS], ready: out_ready};
    assign adv       = !outHs.valid || outHs.ready;
    assign in_ready  = adv;
    assign out_valid = outHs.valid;

    if (N_IN == (1 << SEL_W)) begin : gFullRange
        assign rangeErr = 1'b0;
    end else begin : gPartialRange
        assign rangeErr = (32'(in_sel) >= N_IN);
    end

    // Blanking the lanes up front makes an out-of-range select resolve to zero at the output.
    assign lvlData[0 +: N_IN*DATA_W] = rangeErr ? '0 : in_data;
    assign lvlValid[0]               = in_valid;
    assign lvlSel[0]                 = in_sel;

    for (genvar k = 0; k < LEVELS; k++) begin : gStage
        localparam int unsigned NL    = lanes_at_level(N_IN, k);
        localparam int unsigned NO    = lanes_at_level(N_IN, k + 1);
        localparam int unsigned OFF_I = level_offset(N_IN, k, DATA_W);
        localparam int unsigned OFF_O = level_offset(N_IN, k + 1, DATA_W);

        mux_tree_stage #(
            .DATA_W  (DATA_W),
            .N_LANES (NL),
            .SEL_W   (SEL_W)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (adv),
            .in_valid  (lvlValid[k]),
            .in_data   (lvlData[OFF_I +: NL*DATA_W]),
            .in_sel    (lvlSel[k]),
            .out_valid (lvlValid[k+1]),
            .out_data  (lvlData[OFF_O +: NO*DATA_W]),
            .out_sel   (lvlSel[k+1])
        );
    end

    assign unusedSel = lvlSel[LEVELS];
    assign out_data  = lvlData[level_offset(N_IN, LEVELS, DATA_W) +: DATA_W];

`ifdef MUX_ERR_EN
    logic [LEVELS-1:0] err_d;
    logic [LEVELS-1:0] err_q;

    always_comb begin
        err_d    = err_q;
        err_d[0] = rangeErr;
        for (int k = 1; k < LEVELS; k++) err_d[k] = err_q[k-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
        end else if (adv) begin
            err_q <= err_d;
        end
    end

    assign out_err = err_q[LEVELS-1];
`else
    assign out_err = 1'b0;
`endif

endmodule
